// File: rtl/dec_pkg.sv
// Shared decode-stage types: major opcodes, ALU op codes, FSM states and the
// decoded bundle carried from the decoder to the output register.
package dec_pkg;

  localparam int unsigned NREG  = 4;
  localparam int unsigned IMM_W = 8;

  localparam logic [2:0] MAJ_CAL  = 3'b000;
  localparam logic [2:0] MAJ_CALI = 3'b001;
  localparam logic [2:0] MAJ_LI   = 3'b010;
  localparam logic [2:0] MAJ_LM   = 3'b100;
  localparam logic [2:0] MAJ_SM   = 3'b101;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } dec_state_t;

  typedef struct packed {
    logic [1:0]       aradr;
    logic [1:0]       bradr;
    logic [1:0]       wadr;
    logic [2:0]       op;
    logic             we;
    logic             ll;
    logic             lh;
    logic             imm_sel;
    logic             dmre;
    logic             dmwe;
    logic [IMM_W-1:0] imm;
  } dec_bundle_t;

endpackage

// File: rtl/dec_core.sv
// Combinational instruction decoder: instruction word to decoded bundle plus
// source-use, bubble and halt flags.
module dec_core
  import dec_pkg::*;
(
  input  logic [15:0] instr_i,
  output dec_bundle_t bundle_o,
  output logic        a_use_o,
  output logic        b_use_o,
  output logic        bubble_o,
  output logic        halt_o
);

  logic [2:0] major;
  logic [2:0] addsub;

  assign major  = instr_i[15:13];
  assign addsub = instr_i[12] ? OP_SUB : OP_ADD;

  always_comb begin
    bundle_o     = '0;
    bundle_o.imm = instr_i[7:0];
    a_use_o      = 1'b0;
    b_use_o      = 1'b0;
    bubble_o     = 1'b0;
    halt_o       = 1'b0;
    case (major)
      MAJ_CAL: begin
        if (instr_i[2]) begin
          bundle_o.aradr = instr_i[9:8];
          bundle_o.bradr = instr_i[1:0];
          bundle_o.wadr  = instr_i[11:10];
          bundle_o.op    = instr_i[6:4];
          bundle_o.we    = 1'b1;
          a_use_o        = 1'b1;
          b_use_o        = 1'b1;
        end else begin
          // NOP and HALT both leave the pipe as bubbles
          bubble_o = 1'b1;
          halt_o   = instr_i[0];
        end
      end
      MAJ_CALI: begin
        bundle_o.aradr   = instr_i[9:8];
        bundle_o.wadr    = instr_i[11:10];
        bundle_o.op      = addsub;
        bundle_o.imm_sel = 1'b1;
        bundle_o.we      = 1'b1;
        a_use_o          = 1'b1;
      end
      MAJ_LI: begin
        bundle_o.bradr = instr_i[9:8];
        bundle_o.wadr  = instr_i[11:10];
        bundle_o.we    = 1'b1;
        bundle_o.lh    = instr_i[12];
        bundle_o.ll    = !instr_i[12];
        b_use_o        = 1'b1;
      end
      MAJ_LM: begin
        bundle_o.aradr   = instr_i[9:8];
        bundle_o.wadr    = instr_i[11:10];
        bundle_o.op      = addsub;
        bundle_o.imm_sel = 1'b1;
        bundle_o.dmre    = 1'b1;
        bundle_o.we      = 1'b1;
        a_use_o          = 1'b1;
      end
      MAJ_SM: begin
        bundle_o.aradr   = instr_i[9:8];
        bundle_o.bradr   = instr_i[11:10];
        bundle_o.op      = addsub;
        bundle_o.imm_sel = 1'b1;
        bundle_o.dmwe    = 1'b1;
        a_use_o          = 1'b1;
        b_use_o          = 1'b1;
      end
      default: bubble_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/dec_stage.sv
// Registered decode stage with valid/ready handshake, load-use scoreboard
// and a RUN/DRAIN/HALTED control FSM.
module dec_stage
  import dec_pkg::*;
#(
  parameter int unsigned DW    = 16,
  parameter int unsigned LDLAT = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [15:0]   instr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [1:0]    aradr,
  output logic [1:0]    bradr,
  output logic [1:0]    wadr,
  output logic [2:0]    op,
  output logic          we,
  output logic          ll,
  output logic          lh,
  output logic          imm_sel,
  output logic          dmre,
  output logic          dmwe,
  output logic [DW-1:0] iv,
  output logic          halted
);

  localparam int unsigned CW = $clog2(LDLAT + 1);

  dec_state_t  state_q, state_d;
  dec_bundle_t out_q, out_d;
  logic        out_valid_q, out_valid_d;
  logic        halted_q, halted_d;
  logic [CW-1:0] cnt_q [NREG];
  logic [CW-1:0] cnt_d [NREG];

  dec_bundle_t dec;
  logic        a_use, b_use, bubble, halt;
  logic        hazard, accept, consume, cnt_zero, ld_pend;

  dec_core u_core (
    .instr_i  (instr),
    .bundle_o (dec),
    .a_use_o  (a_use),
    .b_use_o  (b_use),
    .bubble_o (bubble),
    .halt_o   (halt)
  );

  // An LM sitting in the output register has not yet armed its counter
  assign ld_pend = out_valid_q && out_q.dmre;

  always_comb begin
    hazard = 1'b0;
    if (!bubble) begin
      if (a_use && cnt_q[dec.aradr] != '0) hazard = 1'b1;
      if (b_use && cnt_q[dec.bradr] != '0) hazard = 1'b1;
      if (dec.we && cnt_q[dec.wadr] != '0) hazard = 1'b1;
      if (ld_pend && ((a_use && dec.aradr == out_q.wadr) ||
                      (b_use && dec.bradr == out_q.wadr) ||
                      (dec.we && dec.wadr == out_q.wadr)))
        hazard = 1'b1;
    end
  end

  assign in_ready = !rst && (state_q == RUN) && !hazard && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign consume  = out_valid_q && out_ready;

  always_comb begin
    cnt_zero = 1'b1;
    for (int i = 0; i < NREG; i++)
      if (cnt_q[i] != '0) cnt_zero = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;
    halted_d    = halted_q;
    for (int i = 0; i < NREG; i++) begin
      cnt_d[i] = (cnt_q[i] != '0) ? cnt_q[i] - CW'(1) : '0;
      if (consume && out_q.dmre && out_q.wadr == 2'(i))
        cnt_d[i] = CW'(LDLAT);
    end

    if (accept) begin
      out_valid_d = !bubble;
      if (!bubble) out_d = dec;
    end else if (consume) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      RUN:     if (accept && halt) state_d = DRAIN;
      // Wait for the last bundle to leave and any load it issued to retire
      DRAIN:   if ((!out_valid_q || (consume && !out_q.dmre)) && cnt_zero)
                 state_d = HALTED;
      HALTED:  state_d = HALTED;
      default: state_d = RUN;
    endcase
    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      halted_q    <= 1'b0;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      halted_q    <= halted_d;
      for (int i = 0; i < NREG; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out_valid = out_valid_q;
  assign aradr     = out_q.aradr;
  assign bradr     = out_q.bradr;
  assign wadr      = out_q.wadr;
  assign op        = out_q.op;
  assign we        = out_q.we;
  assign ll        = out_q.ll;
  assign lh        = out_q.lh;
  assign imm_sel   = out_q.imm_sel;
  assign dmre      = out_q.dmre;
  assign dmwe      = out_q.dmwe;
  assign iv        = DW'(out_q.imm);
  assign halted    = halted_q;

endmodule

// File: tb/tb_dec_stage.sv
// Directed bench for dec_stage: inputs driven 1 time unit after posedge,
// outputs checked on the falling edge.
module tb_dec_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] instr;
  logic        out_valid;
  logic        out_ready;
  logic [1:0]  aradr, bradr, wadr;
  logic [2:0]  op;
  logic        we, ll, lh, imm_sel, dmre, dmwe;
  logic [15:0] iv;
  logic        halted;

  int total  = 0;
  int passes = 0;

  always #5 clk = ~clk;

  dec_stage #(.DW(16), .LDLAT(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .aradr     (aradr),
    .bradr     (bradr),
    .wadr      (wadr),
    .op        (op),
    .we        (we),
    .ll        (ll),
    .lh        (lh),
    .imm_sel   (imm_sel),
    .dmre      (dmre),
    .dmwe      (dmwe),
    .iv        (iv),
    .halted    (halted)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; instr = 16'h0000;
    tick();
    smp();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_halted", halted, 0);
    chk("rst_wadr", wadr, 0);
    chk("rst_iv", iv, 0);
    chk("rst_we", we, 0);
    tick();
    rst = 1'b0;

    // Streaming CAL reg
    in_valid = 1'b1; instr = 16'h0607;
    smp();
    chk("str_in_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("str_valid", out_valid, 1);
    chk("str_aradr", aradr, 2);
    chk("str_bradr", bradr, 3);
    chk("str_wadr", wadr, 1);
    chk("str_op", op, 0);
    chk("str_we", we, 1);
    chk("str_imm_sel", imm_sel, 0);
    tick();
    smp();
    chk("str_drained", out_valid, 0);

    // Load-use: LM r1 then CAL reading r1
    tick();
    in_valid = 1'b1; instr = 16'h8404;
    smp();
    chk("lu_lm_ready", in_ready, 1);
    tick();
    instr = 16'h0904;
    smp();
    chk("lu_lm_valid", out_valid, 1);
    chk("lu_lm_dmre", dmre, 1);
    chk("lu_lm_wadr", wadr, 1);
    chk("lu_stall0", in_ready, 0);
    tick();
    smp();
    chk("lu_stall1", in_ready, 0);
    chk("lu_bubble", out_valid, 0);
    tick();
    smp();
    chk("lu_stall2", in_ready, 0);
    tick();
    smp();
    chk("lu_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("lu_issue_valid", out_valid, 1);
    chk("lu_issue_aradr", aradr, 1);
    chk("lu_issue_wadr", wadr, 2);
    tick();
    smp();
    chk("lu_issue_once", out_valid, 0);

    // Backpressure on LIL
    tick();
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h4FAB;
    smp();
    chk("bp_accept", in_ready, 1);
    tick();
    instr = 16'h0607;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("bp_valid", out_valid, 1);
      chk("bp_ll", ll, 1);
      chk("bp_lh", lh, 0);
      chk("bp_wadr", wadr, 3);
      chk("bp_iv", iv, 16'h00AB);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    smp();
    chk("bp_release", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_wadr", wadr, 1);
    chk("bp_next_ll", ll, 0);
    tick();

    // Store with subtract
    in_valid = 1'b1; instr = 16'hB601;
    tick();
    in_valid = 1'b0;
    smp();
    chk("sm_valid", out_valid, 1);
    chk("sm_dmwe", dmwe, 1);
    chk("sm_we", we, 0);
    chk("sm_op", op, 1);
    chk("sm_aradr", aradr, 2);
    chk("sm_bradr", bradr, 1);
    chk("sm_iv", iv, 16'h0001);
    chk("sm_dmre", dmre, 0);
    tick();

    // Undefined major is swallowed as a bubble
    in_valid = 1'b1; instr = 16'h6000;
    smp();
    chk("undef_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("undef_no_valid", out_valid, 0);
    tick();

    // Halt after a load: drains, then stops accepting
    in_valid = 1'b1; instr = 16'h8404;
    tick();
    instr = 16'h0001;
    smp();
    chk("halt_accept", in_ready, 1);
    tick();
    instr = 16'h0607;
    smp();
    chk("halt_drain_ready", in_ready, 0);
    chk("halt_drain_valid", out_valid, 0);
    chk("halt_drain_h0", halted, 0);
    tick();
    smp();
    chk("halt_drain_h1", halted, 0);
    tick();
    smp();
    chk("halt_drain_h2", halted, 0);
    tick();
    for (int i = 0; i < 3; i++) begin
      smp();
      chk("halt_halted", halted, 1);
      chk("halt_in_ready", in_ready, 0);
      chk("halt_no_valid", out_valid, 0);
      tick();
    end

    // Reset from HALTED
    rst = 1'b1; in_valid = 1'b0;
    tick();
    rst = 1'b0;
    smp();
    chk("rh_halted", halted, 0);
    chk("rh_ready", in_ready, 1);

    // Reset while in DRAIN with a load counter armed
    tick();
    in_valid = 1'b1; instr = 16'h8404;
    tick();
    instr = 16'h0001;
    tick();
    rst = 1'b1; in_valid = 1'b0;
    smp();
    chk("rd_in_ready_rst", in_ready, 0);
    tick();
    rst = 1'b0; in_valid = 1'b1; instr = 16'h0904;
    smp();
    chk("rd_valid", out_valid, 0);
    chk("rd_halted", halted, 0);
    chk("rd_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    smp();
    chk("rd_issue_valid", out_valid, 1);
    chk("rd_issue_wadr", wadr, 2);
    tick();

    // Reset mid-stall discards the held bundle
    out_ready = 1'b0; in_valid = 1'b1; instr = 16'h4FAB;
    tick();
    in_valid = 1'b0;
    smp();
    chk("rs_held", out_valid, 1);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b1;
    smp();
    chk("rs_valid", out_valid, 0);
    chk("rs_wadr", wadr, 0);
    chk("rs_ll", ll, 0);
    chk("rs_iv", iv, 0);
    tick();

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule

// File: doc/dec_stage.md
DEC_STAGE -- requirements
Module: dec_stage

Interface
REQ-001 The block SHALL have parameter DW, default 16, the width of the extended immediate iv.
REQ-002 The block SHALL have parameter LDLAT, default 2, the load-to-use latency in cycles (range 1..7).
REQ-003 The block SHALL have clk input, 1 bit, the single clock.
REQ-004 The block SHALL have rst input, 1 bit; reset is synchronous and active-high.
REQ-005 The block SHALL have in_valid input, 1 bit, meaning fetch presents an instruction.
REQ-006 The block SHALL have in_ready output, 1 bit, meaning the stage accepts instr this cycle.
REQ-007 The block SHALL have instr input, 16 bits, the instruction word.
REQ-008 The block SHALL have out_valid output, 1 bit, meaning the decoded bundle is valid.
REQ-009 The block SHALL have out_ready input, 1 bit, meaning execute consumes the bundle.
REQ-010 The block SHALL have the following registered decoded outputs: aradr, bradr and wadr (2 bits each); op (3 bits); we, ll, lh, imm_sel, dmre and dmwe (1 bit each); iv (DW bits).
REQ-011 The block SHALL have halted output, 1 bit, meaning the HALT has fully retired.

Function
REQ-012 The stage SHALL be one registered stage: an accepted instruction appears on the outputs the next cycle (latency 1).
REQ-013 A transfer SHALL occur when in_valid && in_ready, and output SHALL be consumed when out_valid && out_ready.
REQ-014 in_ready SHALL equal (state==RUN) && !hazard && (!out_valid || out_ready).
REQ-015 While out_valid && !out_ready, all decoded outputs SHALL hold stable.
REQ-016 Decode for 000, instr[2]=1 (CAL reg) SHALL be: aradr=[9:8], bradr=[1:0], wadr=[11:10], op=[6:4], we=1, imm_sel=0.
REQ-017 Decode for 001 (CAL imm) SHALL be: aradr=[9:8], wadr=[11:10], op=OP_SUB if [12] else OP_ADD, imm_sel=1, we=1.
REQ-018 Decode for 010 (LIL/LIH) SHALL be: bradr=[9:8], wadr=[11:10], we=1, with lh=[12] and ll=![12].
REQ-019 Decode for 100 (LM) SHALL be: aradr=[9:8], wadr=[11:10], op=add/sub per [12], imm_sel=1, dmre=1, we=1.
REQ-020 Decode for 101 (SM) SHALL be: aradr=[9:8], bradr=[11:10], op=add/sub per [12], imm_sel=1, dmwe=1, we=0.
REQ-021 iv SHALL be instr[7:0] zero-extended to DW for all formats.
REQ-022 NOP (000, [2]=0, [0]=0) and undefined majors (011, 110, 111) SHALL be consumed as bubbles, with no out_valid produced.
REQ-023 HALT (000, [2]=0, [0]=1) SHALL be consumed as a bubble, and the FSM SHALL move RUN->DRAIN.
REQ-024 In DRAIN, the FSM SHALL move to HALTED when !out_valid (or the last bundle transfers) and all scoreboard counters are 0.
REQ-025 In HALTED, halted SHALL be 1, in_ready SHALL be 0, and only rst SHALL exit this state.
REQ-026 The scoreboard SHALL hold one counter of width clog2(LDLAT+1) per register (4 counters).
REQ-027 On LM output transfer, the counter for wadr SHALL be set to LDLAT, and non-zero counters SHALL decrement by 1 each cycle.
REQ-028 When a set and a decrement hit the same register in the same cycle, the set SHALL win.
REQ-029 hazard SHALL be 1 when any source register of instr (per REQ-016..020) or its wadr has a non-zero counter.
REQ-030 hazard SHALL also be 1 when a source register or wadr matches wadr of a held, untransferred LM in the output register.
REQ-031 Bubbles (NOP/undefined/HALT) SHALL never raise hazard.

Reset
REQ-032 While rst is 1 on a clock edge, the block SHALL set out_valid=0, halted=0, state=RUN, and all counters=0.
REQ-033 While rst is 1 on a clock edge, all decoded outputs SHALL be 0 and in_ready SHALL be 0.
REQ-034 An rst asserted mid-stall or in DRAIN SHALL discard the held bundle with no transfer.

Structure
REQ-035 Package dec_pkg SHALL hold the major-opcode constants, OP_ADD=3'b000, OP_SUB=3'b001, the state enum {RUN, DRAIN, HALTED} and the decoded-bundle struct.
REQ-036 The combinational decode SHALL be one sub-module, dec_core (instr -> bundle and source-use flags); scoreboard, FSM and the output register SHALL stay in dec_stage.

Verification
REQ-037 Streaming: with out_ready=1, 0x0607 SHALL produce, next cycle, aradr=2, bradr=3, wadr=1, op=0, we=1.
REQ-038 Load-use: 0x8404 then 0x0904 with LDLAT=2 SHALL give in_ready=0 until r1's counter reaches 0, then 0x0904 SHALL issue exactly once.
REQ-039 Backpressure: 0x4FAB with out_ready=0 for 3 cycles SHALL hold ll=1, wadr=3, iv=0x00AB stable, with in_ready=0.
REQ-040 Store: 0xB601 SHALL give dmwe=1, we=0, op=OP_SUB, aradr=2, bradr=1, iv=0x0001.
REQ-041 Halt: 0x8404, 0x0001, 0x0607 SHALL raise halted after the load drains, and 0x0607 SHALL never be accepted.
REQ-042 Reset in DRAIN: rst for 1 cycle SHALL give out_valid=0, halted=0, and in_ready=1 on the next cycle.
